// File: rtl/can_acf_frame_qualifier_if.sv
// Bus between the bit stream processor / register file and the acceptance
// filter. The master side is the BSP plus configuration; the slave side is
// the filter, which returns the accept/drop qualifier to the RX FIFO.
interface can_acf_frame_qualifier_if;
    logic        reset_mode;
    logic        extended_mode;
    logic        acceptance_filter_mode;
    logic [31:0] acr;
    logic [31:0] amr;
    logic        hdr_valid;
    logic [28:0] hdr_id;
    logic        hdr_ide;
    logic        hdr_rtr;
    logic [3:0]  hdr_dlc;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_done;
    logic        frame_abort;
    logic        decision_valid;
    logic        id_ok;
    logic [1:0]  filter_hit;

    modport master (
        output reset_mode, extended_mode, acceptance_filter_mode, acr, amr,
        output hdr_valid, hdr_id, hdr_ide, hdr_rtr, hdr_dlc,
        output byte_valid, byte_data, frame_done, frame_abort,
        input  decision_valid, id_ok, filter_hit
    );

    modport slave (
        input  reset_mode, extended_mode, acceptance_filter_mode, acr, amr,
        input  hdr_valid, hdr_id, hdr_ide, hdr_rtr, hdr_dlc,
        input  byte_valid, byte_data, frame_done, frame_abort,
        output decision_valid, id_ok, filter_hit
    );
endinterface

// File: rtl/can_acf_frame_qualifier.sv
// SJA1000-style sequential acceptance filter. Snapshots the frame header and
// up to two data bytes, evaluates the code/mask filters once, and holds the
// id_ok qualifier until the frame completes or is dropped.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a header; outputs cleared
// CAPTURE | header latched, collecting the data bytes the filter needs
// DECIDE  | all filter inputs present; result registered at the next edge
// HOLD    | decision presented; id_ok held until frame_done/frame_abort
module can_acf_frame_qualifier #(
    parameter bit DATA_FILTER_EN = 1'b1
) (
    input logic                        clk,
    input logic                        rst_n,
    can_acf_frame_qualifier_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DECIDE  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [28:0] r_id;
    logic        r_ide;
    logic        r_rtr;
    logic        r_ext_mode;
    logic        r_single;
    logic [31:0] r_acr;
    logic [31:0] r_amr;
    logic [1:0]  r_need;
    logic [1:0]  r_cnt;
    logic [7:0]  r_b0;
    logic [7:0]  r_b1;

    logic        r_dv;
    logic        r_id_ok;
    logic [1:0]  r_hit;

    logic [1:0]  w_need_new;
    logic        w_latch;
    logic        w_store;
    logic        w_decide;
    logic        w_b0_abs;
    logic        w_b1_abs;
    logic [1:0]  w_hit;
    logic        w_match;

    // Every bit must equal the code unless its mask bit says don't care.
    function automatic logic f_match(input logic [31:0] code,
                                     input logic [31:0] field,
                                     input logic [31:0] mask);
        return &((code ~^ field) | mask);
    endfunction

    // Data bytes only take part for standard data frames in PeliCAN mode;
    // DLC above 8 clamps naturally because at most two bytes are ever used.
    always_comb begin
        w_need_new = 2'd0;
        if (DATA_FILTER_EN && bus.extended_mode && !bus.hdr_ide && !bus.hdr_rtr) begin
            if (bus.acceptance_filter_mode)
                w_need_new = (bus.hdr_dlc >= 4'd2) ? 2'd2 : bus.hdr_dlc[1:0];
            else
                w_need_new = (bus.hdr_dlc != 4'd0) ? 2'd1 : 2'd0;
        end
    end

    // Next-state logic; priority is reset_mode, abort, new header, then the
    // per-state progression.
    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_store  = 1'b0;
        w_decide = 1'b0;
        if (bus.reset_mode) begin
            w_next = S_IDLE;
        end else if (bus.frame_abort) begin
            w_next = S_IDLE;
        end else if (bus.hdr_valid) begin
            w_latch = 1'b1;
            w_next  = (w_need_new == 2'd0) ? S_DECIDE : S_CAPTURE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_CAPTURE: begin
                    if (bus.frame_done) begin
                        w_next = S_IDLE;
                    end else if (bus.byte_valid) begin
                        w_store = 1'b1;
                        if (({1'b0, r_cnt} + 3'd1) >= {1'b0, r_need})
                            w_next = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    // A frame that ends before its result is presented is
                    // treated as truncated and produces no decision.
                    if (bus.frame_done) begin
                        w_next = S_IDLE;
                    end else begin
                        w_decide = 1'b1;
                        w_next   = S_HOLD;
                    end
                end
                S_HOLD: if (bus.frame_done) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Header/config snapshot and data byte capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id       <= '0;
            r_ide      <= 1'b0;
            r_rtr      <= 1'b0;
            r_ext_mode <= 1'b0;
            r_single   <= 1'b0;
            r_acr      <= '0;
            r_amr      <= '0;
            r_need     <= 2'd0;
            r_cnt      <= 2'd0;
            r_b0       <= 8'h00;
            r_b1       <= 8'h00;
        end else if (w_latch) begin
            r_id       <= bus.hdr_id;
            r_ide      <= bus.hdr_ide;
            r_rtr      <= bus.hdr_rtr;
            r_ext_mode <= bus.extended_mode;
            r_single   <= bus.acceptance_filter_mode;
            r_acr      <= bus.acr;
            r_amr      <= bus.amr;
            r_need     <= w_need_new;
            r_cnt      <= 2'd0;
            r_b0       <= 8'h00;
            r_b1       <= 8'h00;
        end else if (w_store) begin
            if (r_cnt == 2'd0)      r_b0 <= bus.byte_data;
            else if (r_cnt == 2'd1) r_b1 <= bus.byte_data;
            r_cnt <= r_cnt + 2'd1;
        end else if (w_next == S_IDLE) begin
            r_cnt <= 2'd0;
        end
    end

    // Filter evaluation on the snapshot; bytes not required are don't care.
    always_comb begin
        w_b0_abs = (r_need == 2'd0);
        w_b1_abs = (r_need < 2'd2);
        w_hit    = 2'b00;
        if (!r_ext_mode) begin
            w_hit[0] = !r_ide &&
                       f_match({24'h0, r_acr[31:24]}, {24'h0, r_id[10:3]},
                               {24'hFF_FFFF, r_amr[31:24]});
        end else if (r_single) begin
            if (r_ide)
                w_hit[0] = f_match(r_acr, {r_id, r_rtr, 2'b00}, r_amr | 32'h0000_0003);
            else
                w_hit[0] = f_match(r_acr,
                                   {r_id[10:0], r_rtr, 4'h0, r_b0, r_b1},
                                   r_amr | {16'h000F,
                                            (w_b0_abs ? 8'hFF : 8'h00),
                                            (w_b1_abs ? 8'hFF : 8'h00)});
        end else begin
            if (r_ide) begin
                w_hit[0] = f_match({16'h0, r_acr[31:16]}, {16'h0, r_id[28:13]},
                                   {16'hFFFF, r_amr[31:16]});
                w_hit[1] = f_match({16'h0, r_acr[15:0]}, {16'h0, r_id[28:13]},
                                   {16'hFFFF, r_amr[15:0]});
            end else begin
                w_hit[0] = f_match({12'h0, r_acr[31:16], r_acr[3:0]},
                                   {12'h0, r_id[10:0], r_rtr, r_b0},
                                   {12'hFFF, r_amr[31:16], r_amr[3:0]} |
                                   {24'h0, (w_b0_abs ? 8'hFF : 8'h00)});
                w_hit[1] = f_match({20'h0, r_acr[15:4]}, {20'h0, r_id[10:0], r_rtr},
                                   {20'hF_FFFF, r_amr[15:4]});
            end
        end
        w_match = |w_hit;
    end

    // Registered qualifier: pulse on decision, hold until the frame ends or
    // is replaced by a new header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dv    <= 1'b0;
            r_id_ok <= 1'b0;
            r_hit   <= 2'b00;
        end else begin
            r_dv <= w_decide;
            if (w_decide) begin
                r_id_ok <= w_match;
                r_hit   <= w_hit;
            end else if (w_latch || (w_next == S_IDLE)) begin
                r_id_ok <= 1'b0;
                r_hit   <= 2'b00;
            end
        end
    end

    assign bus.decision_valid = r_dv;
    assign bus.id_ok          = r_id_ok;
    assign bus.filter_hit     = r_hit;

endmodule
